register_file: RTL and testbench

// - MIPS-style general-purpose register file for the single-cycle/pipelined datapath.
// - Holds 32 x 32-bit registers with two combinational read ports and one

---
 rtl/rf_pkg.sv | 27 ++
 rtl/rf_read_port.sv | 18 +
 rtl/register_file.sv | 42 ++++
 tb/tb_register_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file sizing, the zero-register index and MIPS register names
// used by both the register file and the instruction decoder.
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  // Architectural register names, shared with the decoder for rs/rt/rd decoding.
  typedef enum logic [ADDR_WIDTH-1:0] {
    ZERO = 5'd0,  AT = 5'd1,  V0 = 5'd2,  V1 = 5'd3,
    A0   = 5'd4,  A1 = 5'd5,  A2 = 5'd6,  A3 = 5'd7,
    T0   = 5'd8,  T1 = 5'd9,  T2 = 5'd10, T3 = 5'd11,
    T4   = 5'd12, T5 = 5'd13, T6 = 5'd14, T7 = 5'd15,
    S0   = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19,
    S4   = 5'd20, S5 = 5'd21, S6 = 5'd22, S7 = 5'd23,
    T8   = 5'd24, T9 = 5'd25, K0 = 5'd26, K1 = 5'd27,
    GP   = 5'd28, SP = 5'd29, FP = 5'd30, RA = 5'd31
  } regName_e;

  function automatic logic isZeroReg(input logic [ADDR_WIDTH-1:0] index);
    return index == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: selects a register by index, with index 0
// forced to read zero whatever the storage holds.
module rf_read_port
  import rf_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] readIndex,
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  output logic [DATA_WIDTH-1:0] readData
);

  always_comb begin
    readData = regs[readIndex];
    if (isZeroReg(readIndex)) begin
      readData = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS-style 32 x 32-bit register file: two combinational read ports, one
// clocked write port, register 0 hardwired to zero, no read-during-write bypass.
module register_file
  import rf_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Reset wins over a same-cycle write; writes aimed at register 0 are dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && !isZeroReg(WriteRegister)) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  rf_read_port readPort1 (
    .readIndex (ReadRegister1),
    .regs      (regs),
    .readData  (ReadData1)
  );

  rf_read_port readPort2 (
    .readIndex (ReadRegister2),
    .regs      (regs),
    .readData  (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed corner cases, a table of
// read-pair vectors, and randomized traffic against an array-based model.
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  typedef struct {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } readVec_t;

  readVec_t vecs [12];

  register_file dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : model[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] exp1, input logic [31:0] exp2);
    checks++;
    if (ReadData1 !== exp1) begin
      errors++;
      $display("[TB] FAIL %s port1: got %h expected %h", name, ReadData1, exp1);
    end
    checks++;
    if (ReadData2 !== exp2) begin
      errors++;
      $display("[TB] FAIL %s port2: got %h expected %h", name, ReadData2, exp2);
    end
  endtask

  // Drive one cycle of inputs; optionally check reads before the edge, then
  // advance the model across the edge and check reads after it.
  task automatic applyStimulus(input string name, input logic rst, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2,
                               input bit checkPre);
    Reset = rst;
    RegWrite = we;
    WriteRegister = wa;
    WriteData = wd;
    ReadRegister1 = ra1;
    ReadRegister2 = ra2;
    #1;
    if (checkPre) checkOutput({name, "_pre"}, modelRead(ra1), modelRead(ra2));
    @(posedge Clk);
    #1;
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we === 1'b1 && wa != 5'd0) begin
      model[wa] = wd;
    end
    checkOutput({name, "_post"}, modelRead(ra1), modelRead(ra2));
  endtask

  initial begin
    Reset = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
    @(negedge Clk);

    // Reset, then reads of 8 and 25 are zero.
    applyStimulus("reset", 1'b1, 1'b0, 5'd0, 32'd0, 5'd8, 5'd25, 1'b0);
    checkOutput("resetConst", 32'd0, 32'd0);

    // Write to reg 0 is discarded.
    applyStimulus("writeZero", 1'b0, 1'b1, 5'd0, 32'd7, 5'd0, 5'd31, 1'b1);
    checkOutput("writeZeroConst", 32'd0, 32'd0);

    // Write 11 then 42 to reg 31: old value before the edge, new after it.
    applyStimulus("write31a", 1'b0, 1'b1, 5'd31, 32'd11, 5'd0, 5'd31, 1'b1);
    checkOutput("write31aConst", 32'd0, 32'd11);
    Reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 32'd42;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #1;
    checkOutput("rdwBefore", 32'd11, 32'd11);
    @(posedge Clk);
    #1;
    model[31] = 32'd42;
    checkOutput("rdwAfter", 32'd42, 32'd42);

    // Fill regs 8..25 with 100+i.
    for (int i = 8; i <= 25; i++) begin
      applyStimulus("fill", 1'b0, 1'b1, 5'(i), 32'(100 + i), 5'(i), 5'd0, 1'b1);
    end

    for (int i = 0; i < 9; i++) begin
      vecs[i] = '{r1: 5'(8 + 2*i), r2: 5'(9 + 2*i), e1: 32'(108 + 2*i), e2: 32'(109 + 2*i)};
    end
    vecs[9]  = '{r1: 5'd8,  r2: 5'd8,  e1: 32'd108, e2: 32'd108};
    vecs[10] = '{r1: 5'd25, r2: 5'd25, e1: 32'd125, e2: 32'd125};
    vecs[11] = '{r1: 5'd0,  r2: 5'd31, e1: 32'd0,   e2: 32'd42};
    RegWrite = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ReadRegister1 = vecs[i].r1;
      ReadRegister2 = vecs[i].r2;
      #1;
      checkOutput($sformatf("pairTable%0d", i), vecs[i].e1, vecs[i].e2);
    end

    // RegWrite low, and RegWrite unknown, must not write.
    applyStimulus("noWrite", 1'b0, 1'b0, 5'd8, 32'hDEADBEEF, 5'd8, 5'd9, 1'b1);
    checkOutput("noWriteConst", 32'd108, 32'd109);
    applyStimulus("xWrite", 1'b0, 1'bx, 5'd9, 32'hCAFEF00D, 5'd8, 5'd9, 1'b1);
    checkOutput("xWriteConst", 32'd108, 32'd109);

    // Reset has priority over a same-cycle write.
    applyStimulus("resetVsWrite", 1'b1, 1'b1, 5'd9, 32'd5, 5'd9, 5'd8, 1'b1);
    checkOutput("resetVsWriteConst", 32'd0, 32'd0);

    // Randomized traffic against the model, often reading the write target.
    for (int n = 0; n < 400; n++) begin
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      rst = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus("random", rst, we, wa, wd, ra1, ra2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
